// File: rtl/tick_scheduler.sv
// tick_scheduler: multi-channel one-shot/periodic timer driven by 5 ms / 50 ms divider ticks,
// with round-robin expiry events presented through a registered valid/ready output.
// Latency: an expiring tick at edge k sets pending after k; the event is presented after k+1
// when the output register is free.
// Backpressure: the event register holds while evt_valid && !evt_ready, and further expiries
// queue as one pending flag per channel. A second expiry on a still-pending channel sets overrun.
//
// Ports:
//   clk_in, rst                - system clock, asynchronous active-high reset
//   five_ms_tick, fifty_ms_tick - one-cycle tick pulses from the clock divider
//   cfg_valid/cfg_ready       - configuration handshake (ready whenever not in reset)
//   cfg_chan/src/count/periodic/stop - configuration payload
//   evt_valid/evt_ready/evt_chan - expiry event output
//   busy, overrun             - per-channel armed and sticky lost-event flags
module tick_scheduler #(
  parameter  int NCHAN = 4,
  parameter  int CW    = 8,
  localparam int CHW   = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             five_ms_tick,
  input  logic             fifty_ms_tick,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CHW-1:0]   cfg_chan,
  input  logic             cfg_src,
  input  logic [CW-1:0]    cfg_count,
  input  logic             cfg_periodic,
  input  logic             cfg_stop,
  output logic             evt_valid,
  output logic [CHW-1:0]   evt_chan,
  input  logic             evt_ready,
  output logic [NCHAN-1:0] busy,
  output logic [NCHAN-1:0] overrun
);

  // Per-channel state
  logic [CW-1:0]    r_remaining [NCHAN];
  logic [CW-1:0]    r_count     [NCHAN];
  logic [NCHAN-1:0] r_src;
  logic [NCHAN-1:0] r_periodic;
  logic [NCHAN-1:0] r_busy;
  logic [NCHAN-1:0] r_pending;
  logic [NCHAN-1:0] r_overrun;

  // Output event register and round-robin start pointer
  logic             r_evt_valid;
  logic [CHW-1:0]   r_evt_chan;
  logic [CHW-1:0]   r_rr_ptr;

  // Combinational helpers
  logic [NCHAN-1:0] w_tick;
  logic [NCHAN-1:0] w_cfg_hit;
  logic [NCHAN-1:0] w_cand;
  logic [NCHAN-1:0] w_grant_oh;
  logic [CW-1:0]    w_load_cnt;
  logic             w_out_load;
  logic             w_found;
  logic [CHW-1:0]   w_win;
  logic [CHW-1:0]   w_pos;
  logic [CHW-1:0]   w_next_ptr;

  // A count of zero would never expire through a decrement, so it is armed as one tick.
  assign w_load_cnt = (cfg_count == '0) ? CW'(1) : cfg_count;

  // The output register may take a new event when empty or being consumed this edge.
  assign w_out_load = !r_evt_valid || evt_ready;

  always_comb begin
    w_tick    = '0;
    w_cfg_hit = '0;
    for (int c = 0; c < NCHAN; c++) begin
      w_tick[c]    = r_busy[c] && (r_src[c] ? fifty_ms_tick : five_ms_tick);
      w_cfg_hit[c] = cfg_valid && (cfg_chan == CHW'(c));
    end
  end

  // A channel being reconfigured this edge loses its pending event, so it must not be granted.
  assign w_cand = r_pending & ~w_cfg_hit;

  // Round-robin search starting at r_rr_ptr (the channel after the last grant).
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_pos   = '0;
    for (int i = 0; i < NCHAN; i++) begin
      w_pos = CHW'((int'(r_rr_ptr) + i) % NCHAN);
      if (!w_found && w_cand[w_pos]) begin
        w_found = 1'b1;
        w_win   = w_pos;
      end
    end
  end

  assign w_next_ptr = CHW'((int'(w_win) + 1) % NCHAN);

  always_comb begin
    w_grant_oh = '0;
    for (int c = 0; c < NCHAN; c++) begin
      w_grant_oh[c] = w_out_load && w_found && (w_win == CHW'(c));
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCHAN; c++) begin
        r_remaining[c] <= '0;
        r_count[c]     <= '0;
      end
      r_src       <= '0;
      r_periodic  <= '0;
      r_busy      <= '0;
      r_pending   <= '0;
      r_overrun   <= '0;
      r_evt_valid <= 1'b0;
      r_evt_chan  <= '0;
      r_rr_ptr    <= '0;
    end else begin
      for (int c = 0; c < NCHAN; c++) begin
        if (w_cfg_hit[c]) begin
          // Configuration overrides any tick landing on this channel in the same cycle.
          r_pending[c] <= 1'b0;
          r_overrun[c] <= 1'b0;
          if (cfg_stop) begin
            r_busy[c] <= 1'b0;
          end else begin
            r_remaining[c] <= w_load_cnt;
            r_count[c]     <= w_load_cnt;
            r_src[c]       <= cfg_src;
            r_periodic[c]  <= cfg_periodic;
            r_busy[c]      <= 1'b1;
          end
        end else begin
          if (w_grant_oh[c]) begin
            r_pending[c] <= 1'b0;
          end
          if (w_tick[c]) begin
            if (r_remaining[c] == CW'(1)) begin
              // An expiry on the granted channel is a fresh event and overrides the grant clear.
              r_pending[c] <= 1'b1;
              if (r_pending[c] && !w_grant_oh[c]) begin
                r_overrun[c] <= 1'b1;
              end
              if (r_periodic[c]) begin
                r_remaining[c] <= r_count[c];
              end else begin
                r_remaining[c] <= '0;
                r_busy[c]      <= 1'b0;
              end
            end else begin
              r_remaining[c] <= r_remaining[c] - CW'(1);
            end
          end
        end
      end

      if (w_out_load) begin
        if (w_found) begin
          r_evt_valid <= 1'b1;
          r_evt_chan  <= w_win;
          r_rr_ptr    <= w_next_ptr;
        end else begin
          r_evt_valid <= 1'b0;
        end
      end
    end
  end

  assign cfg_ready = !rst;
  assign evt_valid = r_evt_valid;
  assign evt_chan  = r_evt_chan;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_tick_scheduler.sv
// Testbench for tick_scheduler: directed scenarios followed by a randomized run,
// with every output compared each cycle against a behavioural model.
module tb_tick_scheduler;
  localparam int N  = 4;
  localparam int CW = 8;

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic          five_ms_tick = 1'b0;
  logic          fifty_ms_tick = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [1:0]    cfg_chan = '0;
  logic          cfg_src = 1'b0;
  logic [CW-1:0] cfg_count = '0;
  logic          cfg_periodic = 1'b0;
  logic          cfg_stop = 1'b0;
  logic          evt_valid;
  logic [1:0]    evt_chan;
  logic          evt_ready = 1'b1;
  logic [N-1:0]  busy;
  logic [N-1:0]  overrun;

  tick_scheduler #(.NCHAN(N), .CW(CW)) dut (
    .clk_in(clk_in), .rst(rst),
    .five_ms_tick(five_ms_tick), .fifty_ms_tick(fifty_ms_tick),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
    .cfg_src(cfg_src), .cfg_count(cfg_count), .cfg_periodic(cfg_periodic),
    .cfg_stop(cfg_stop),
    .evt_valid(evt_valid), .evt_chan(evt_chan), .evt_ready(evt_ready),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: ticks left, reload value, source, mode, armed, pending, lost flag.
  int m_rem [N];
  int m_cnt [N];
  int m_src [N];
  int m_per [N];
  int m_busy[N];
  int m_pend[N];
  int m_ovr [N];
  int m_vld;
  int m_chan;
  int m_last;   // last granted channel; search begins at the one after it

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_rem[c] = 0; m_cnt[c] = 0; m_src[c] = 0; m_per[c] = 0;
      m_busy[c] = 0; m_pend[c] = 0; m_ovr[c] = 0;
    end
    m_vld  = 0;
    m_chan = 0;
    m_last = N - 1;
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_edge();
    int g;
    int sel;
    int was;
    int hit[N];
    int tk;
    if (rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < N; c++) hit[c] = (cfg_valid && int'(cfg_chan) == c) ? 1 : 0;
    g = -1;
    if (m_vld == 0 || evt_ready) begin
      for (int k = 1; k <= N; k++) begin
        sel = (m_last + k) % N;
        if (g < 0 && m_pend[sel] != 0 && hit[sel] == 0) g = sel;
      end
      if (g >= 0) begin
        m_vld = 1; m_chan = g; m_last = g;
      end else begin
        m_vld = 0;
      end
    end
    for (int c = 0; c < N; c++) begin
      if (hit[c] != 0) begin
        m_pend[c] = 0;
        m_ovr[c]  = 0;
        if (cfg_stop) begin
          m_busy[c] = 0;
        end else begin
          m_rem[c]  = (cfg_count == 0) ? 1 : int'(cfg_count);
          m_cnt[c]  = m_rem[c];
          m_src[c]  = int'(cfg_src);
          m_per[c]  = int'(cfg_periodic);
          m_busy[c] = 1;
        end
      end else begin
        was = m_pend[c];
        if (c == g) m_pend[c] = 0;
        tk = (m_src[c] != 0) ? int'(fifty_ms_tick) : int'(five_ms_tick);
        if (m_busy[c] != 0 && tk != 0) begin
          if (m_rem[c] == 1) begin
            if (was != 0 && c != g) m_ovr[c] = 1;
            m_pend[c] = 1;
            if (m_per[c] != 0) m_rem[c] = m_cnt[c];
            else m_busy[c] = 0;
          end else begin
            m_rem[c] = m_rem[c] - 1;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] eb;
    logic [N-1:0] eo;
    for (int c = 0; c < N; c++) begin
      eb[c] = (m_busy[c] != 0);
      eo[c] = (m_ovr[c] != 0);
    end
    chk("evt_valid", {31'd0, evt_valid}, m_vld);
    if (m_vld != 0) chk("evt_chan", {30'd0, evt_chan}, m_chan);
    chk("busy", {28'd0, busy}, {28'd0, eb});
    chk("overrun", {28'd0, overrun}, {28'd0, eo});
    chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, !rst});
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_in);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    five_ms_tick = 0; fifty_ms_tick = 0; cfg_valid = 0; cfg_stop = 0;
  endtask

  task automatic cfg(input int ch, input int src, input int cnt, input int per);
    cfg_valid = 1; cfg_chan = 2'(ch); cfg_src = src[0]; cfg_count = CW'(cnt);
    cfg_periodic = per[0]; cfg_stop = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    chk("rst_evt_chan", {30'd0, evt_chan}, 32'd0);
    step();
    rst = 0;
    step();
  endtask

  initial begin
    model_reset();
    evt_ready = 1;
    do_reset();

    // One-shot ch1, count 3 on the 5 ms tick
    cfg(1, 0, 3, 0); step(); idle_inputs();
    chk("oneshot_busy", {28'd0, busy}, 32'h2);
    for (int t = 0; t < 3; t++) begin
      five_ms_tick = 1; step(); five_ms_tick = 0;
      if (t < 2) begin
        fifty_ms_tick = 1; step(); fifty_ms_tick = 0;   // other source is ignored
      end
    end
    chk("oneshot_busy_clear", {28'd0, busy}, 32'h0);
    chk("oneshot_not_yet", {31'd0, evt_valid}, 32'd0);
    step();
    chk("oneshot_evt", {30'd0, evt_chan, evt_valid}, 32'h3);
    step();
    chk("oneshot_single", {31'd0, evt_valid}, 32'd0);

    // Periodic ch0 on the 50 ms tick, consumer stalled
    do_reset();
    evt_ready = 0;
    cfg(0, 1, 2, 1); step(); idle_inputs();
    for (int t = 0; t < 6; t++) begin
      fifty_ms_tick = 1; step(); fifty_ms_tick = 0; step();
    end
    chk("periodic_held", {30'd0, evt_chan, evt_valid}, 32'h1);
    chk("periodic_overrun", {28'd0, overrun}, 32'h1);
    cfg(0, 1, 2, 1); step(); idle_inputs();
    chk("periodic_ovr_cleared", {28'd0, overrun}, 32'h0);
    chk("periodic_still_held", {30'd0, evt_chan, evt_valid}, 32'h1);
    evt_ready = 1;

    // All four channels expire together; round robin from channel 0
    for (int round = 0; round < 2; round++) begin
      do_reset();
      for (int c = 0; c < N; c++) begin
        cfg(c, 0, 1, 0); step();
      end
      idle_inputs();
      five_ms_tick = 1; step(); five_ms_tick = 0;
      for (int c = 0; c < N; c++) begin
        step();
        chk("rr_order", {30'd0, evt_chan, evt_valid}, {30'd0, 2'(c), 1'b1});
      end
      step();
      chk("rr_drained", {31'd0, evt_valid}, 32'd0);
    end

    // Reconfigure ch2 on the same edge as its expiring tick
    do_reset();
    cfg(2, 0, 2, 0); step(); idle_inputs();
    five_ms_tick = 1; step();
    cfg(2, 0, 3, 0); step(); idle_inputs();
    step();
    chk("cfg_prio_no_evt", {31'd0, evt_valid}, 32'd0);
    for (int t = 0; t < 3; t++) begin
      five_ms_tick = 1; step(); five_ms_tick = 0; step();
      if (t < 2) chk("cfg_prio_reload_wait", {31'd0, evt_valid}, 32'd0);
    end
    chk("cfg_prio_reload_evt", {30'd0, evt_chan, evt_valid}, 32'h5);

    // Stop ch3 one edge before its expiring tick
    do_reset();
    cfg(3, 0, 2, 0); step(); idle_inputs();
    five_ms_tick = 1; step(); five_ms_tick = 0;
    cfg(3, 0, 2, 0); cfg_stop = 1; step(); idle_inputs();
    five_ms_tick = 1; step(); five_ms_tick = 0;
    step(); step();
    chk("stop_no_evt", {31'd0, evt_valid}, 32'd0);
    chk("stop_busy", {28'd0, busy}, 32'h0);

    // Reset while an event is presented and another pending
    do_reset();
    evt_ready = 0;
    cfg(0, 0, 1, 1); step();
    cfg(1, 0, 1, 1); step(); idle_inputs();
    five_ms_tick = 1; step(); five_ms_tick = 0;
    step();
    chk("rst_pre_evt", {30'd0, evt_chan, evt_valid}, 32'h1);
    rst = 1;
    #1;
    model_reset();
    compare_all();
    chk("rst_async_evt", {31'd0, evt_valid}, 32'd0);
    chk("rst_async_busy", {28'd0, busy}, 32'h0);
    step();
    rst = 0;
    evt_ready = 1;
    for (int t = 0; t < 10; t++) begin
      five_ms_tick = t[0]; fifty_ms_tick = (t == 5); step();
      chk("rst_no_evt", {31'd0, evt_valid}, 32'd0);
    end
    idle_inputs();

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      five_ms_tick  = ($urandom % 4) == 0;
      fifty_ms_tick = ($urandom % 9) == 0;
      cfg_valid     = ($urandom % 6) == 0;
      cfg_chan      = 2'($urandom % 4);
      cfg_src       = 1'($urandom % 2);
      cfg_count     = CW'($urandom % 5);
      cfg_periodic  = 1'($urandom % 2);
      cfg_stop      = ($urandom % 7) == 0;
      evt_ready     = ($urandom % 3) != 0;
      rst           = (i % 997) == 500;
      step();
    end
    rst = 0;
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
